// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer for the table-lookup NCO: walks a linear staircase of
// phase steps, loading each one and holding it for a fixed number of samples.
module nco_sweep_ctrl #(
    parameter int W  = 32,
    parameter int NW = 16,
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_loop,
    input  logic [W-1:0]  i_f_start,
    input  logic [W-1:0]  i_f_step,
    input  logic [NW-1:0] i_n_steps,
    input  logic [DW-1:0] i_dwell,
    input  logic [CW-1:0] i_div,
    output logic          o_ld,
    output logic [W-1:0]  o_dphase,
    output logic          o_ce,
    output logic          o_busy,
    output logic          o_done,
    output logic [NW-1:0] o_step_idx
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t        r_state;
    logic [W-1:0]  r_f_start, r_f_step, r_cur;
    logic [NW-1:0] r_n_last, r_idx;
    logic [DW-1:0] r_dwell_last, r_dwell_cnt;
    logic [CW-1:0] r_div, r_div_cnt;
    logic          r_loop, r_ld, r_ce, r_busy, r_done;

    // Zero counts behave as one, so store "last index" values directly.
    logic [NW-1:0] w_n_last;
    logic [DW-1:0] w_dwell_last;
    logic [CW-1:0] w_div_cnt_inc;
    assign w_n_last      = (i_n_steps == '0) ? '0 : i_n_steps - NW'(1);
    assign w_dwell_last  = (i_dwell == '0) ? '0 : i_dwell - DW'(1);
    assign w_div_cnt_inc = r_div_cnt + CW'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_f_start    <= '0;
            r_f_step     <= '0;
            r_cur        <= '0;
            r_n_last     <= '0;
            r_idx        <= '0;
            r_dwell_last <= '0;
            r_dwell_cnt  <= '0;
            r_div        <= '0;
            r_div_cnt    <= '0;
            r_loop       <= 1'b0;
            r_ld         <= 1'b0;
            r_ce         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_ld   <= 1'b0;
            r_ce   <= 1'b0;
            r_done <= 1'b0;
            if (i_abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_f_start    <= i_f_start;
                            r_f_step     <= i_f_step;
                            r_n_last     <= w_n_last;
                            r_dwell_last <= w_dwell_last;
                            r_div        <= i_div;
                            r_loop       <= i_loop;
                            r_cur        <= i_f_start;
                            r_idx        <= '0;
                            r_state      <= S_LOAD;
                            r_ld         <= 1'b1;
                            r_busy       <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        r_div_cnt   <= '0;
                        r_dwell_cnt <= '0;
                        r_state     <= S_RUN;
                        r_ce        <= (r_div == '0);
                    end
                    S_RUN: begin
                        // r_ce is high exactly in the cycle the divider reaches r_div.
                        if (r_ce) begin
                            if (r_dwell_cnt == r_dwell_last) begin
                                if (r_idx != r_n_last) begin
                                    r_cur   <= r_cur + r_f_step;
                                    r_idx   <= r_idx + NW'(1);
                                    r_state <= S_LOAD;
                                    r_ld    <= 1'b1;
                                end else if (r_loop) begin
                                    r_cur   <= r_f_start;
                                    r_idx   <= '0;
                                    r_state <= S_LOAD;
                                    r_ld    <= 1'b1;
                                end else begin
                                    r_state <= S_IDLE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_dwell_cnt <= r_dwell_cnt + DW'(1);
                                r_div_cnt   <= '0;
                                r_ce        <= (r_div == '0);
                            end
                        end else begin
                            r_div_cnt <= w_div_cnt_inc;
                            r_ce      <= (w_div_cnt_inc == r_div);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_ld       = r_ld;
    assign o_dphase   = r_cur;
    assign o_ce       = r_ce;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_step_idx = r_idx;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: each start pushes the expected ld/ce/done
// timeline computed arithmetically; a negedge monitor pops and compares.
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1, i_start = 1'b0, i_abort = 1'b0, i_loop = 1'b0;
    logic [31:0] i_f_start = '0, i_f_step = '0;
    logic [15:0] i_n_steps = '0, i_dwell = '0, i_div = '0;
    logic        o_ld, o_ce, o_busy, o_done;
    logic [31:0] o_dphase;
    logic [15:0] o_step_idx;

    nco_sweep_ctrl #(.W(32), .NW(16), .DW(16), .CW(16)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
        .i_loop(i_loop), .i_f_start(i_f_start), .i_f_step(i_f_step),
        .i_n_steps(i_n_steps), .i_dwell(i_dwell), .i_div(i_div),
        .o_ld(o_ld), .o_dphase(o_dphase), .o_ce(o_ce), .o_busy(o_busy),
        .o_done(o_done), .o_step_idx(o_step_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 = ld, 1 = ce, 2 = done
        int          cyc;
        logic [31:0] dp;
        logic [15:0] idx;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  n_vec = 0, n_err = 0;
    int  busy_lo = 1, busy_hi = 0;
    bit  mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic pop_check(input int kind, input string name);
        ev_t e;
        if (q.size() == 0) begin
            chk({name, "_unexpected"}, 64'(kind), 64'hFFFF);
            return;
        end
        e = q.pop_front();
        chk({name, "_kind"}, 64'(kind), 64'(e.kind));
        chk({name, "_cycle"}, 64'(cyc), 64'(e.cyc));
        if (kind == 0) begin
            chk("ld_dphase", 64'(o_dphase), 64'(e.dp));
            chk("ld_idx", 64'(o_step_idx), 64'(e.idx));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", 64'(o_busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
            if (o_ld)   pop_check(0, "ld");
            if (o_ce)   pop_check(1, "ce");
            if (o_done) pop_check(2, "done");
        end
    end

    // Reference timeline: step k loads at t0+1+k*P, its samples land every div+1
    // clocks after the load, and the done pulse follows the last busy cycle.
    task automatic run_sweep(input bit lp, input logic [31:0] fs, input logic [31:0] st,
                             input int n, input int dw, input int dv, input int cut,
                             input bit use_rst, input bit busy_start);
        int ne, de, P, t0, stop, nat_end, t, tc, k, end_cyc;
        ev_t e;
        ne = (n == 0) ? 1 : n;
        de = (dw == 0) ? 1 : dw;
        P  = 1 + de * (dv + 1);
        @(posedge clk); #1;
        t0 = cyc;
        i_start = 1'b1; i_loop = lp; i_f_start = fs; i_f_step = st;
        i_n_steps = 16'(n); i_dwell = 16'(dw); i_div = 16'(dv);
        nat_end = lp ? 32'h3FFF_FFFF : t0 + ne * P;
        stop    = (cut > 0) ? t0 + cut : 32'h3FFF_FFFF;
        busy_lo = t0 + 1;
        busy_hi = (nat_end < stop) ? nat_end : stop;
        k = 0;
        while (1) begin
            t = t0 + 1 + k * P;
            if (!lp && k >= ne) break;
            if (t > stop) break;
            e.kind = 0; e.cyc = t; e.dp = fs + st * 32'(k % ne); e.idx = 16'(k % ne);
            q.push_back(e);
            for (int j = 0; j < de; j++) begin
                tc = t + 1 + j * (dv + 1) + dv;
                if (tc <= stop) begin
                    e.kind = 1; e.cyc = tc;
                    q.push_back(e);
                end
            end
            k++;
        end
        if (!lp && t0 + 1 + ne * P <= stop) begin
            e.kind = 2; e.cyc = t0 + 1 + ne * P;
            q.push_back(e);
        end
        end_cyc = busy_hi + 3;
        if (cut > 0 && t0 + cut + 2 > end_cyc) end_cyc = t0 + cut + 2;
        while (cyc < end_cyc) begin
            @(posedge clk); #1;
            i_start = 1'b0; i_abort = 1'b0; i_reset = 1'b0;
            // Scramble the config inputs: the running sweep must ignore them.
            i_loop = 1'($urandom); i_f_start = $urandom; i_f_step = $urandom;
            i_n_steps = 16'($urandom); i_dwell = 16'($urandom); i_div = 16'($urandom);
            if (busy_start && cyc == t0 + 3 && busy_hi >= t0 + 3) i_start = 1'b1;
            if (cut > 0 && cyc == t0 + cut) begin
                if (use_rst) i_reset = 1'b1;
                else         i_abort = 1'b1;
            end
            if (use_rst && cut > 0 && cyc == t0 + cut + 1) begin
                @(negedge clk);
                chk("rst_dphase", 64'(o_dphase), 64'h0);
                chk("rst_idx", 64'(o_step_idx), 64'h0);
            end
        end
        chk("leftover_events", 64'(q.size()), 64'h0);
        q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dw, dv, cut;
        bit lp, rs;
        i_reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ld", 64'(o_ld), 64'h0);
        chk("reset_ce", 64'(o_ce), 64'h0);
        chk("reset_busy", 64'(o_busy), 64'h0);
        chk("reset_done", 64'(o_done), 64'h0);
        chk("reset_dphase", 64'(o_dphase), 64'h0);
        chk("reset_idx", 64'(o_step_idx), 64'h0);
        @(posedge clk); #1;
        i_reset = 1'b0;
        mon_en  = 1'b1;

        run_sweep(1'b0, 32'h0100_0000, 32'h0080_0000, 3, 2, 1, 0, 1'b0, 1'b0);
        run_sweep(1'b0, 32'hFFFF_FFF0, 32'h0000_0020, 2, 1, 0, 0, 1'b0, 1'b0);
        run_sweep(1'b0, 32'h1234_5678, 32'h0000_0100, 0, 0, 0, 0, 1'b0, 1'b0);
        run_sweep(1'b1, 32'h0000_1000, 32'h0000_0010, 2, 1, 0, 6, 1'b0, 1'b0);
        run_sweep(1'b0, 32'h0100_0000, 32'h0080_0000, 3, 2, 1, 0, 1'b0, 1'b1);

        // Start and abort together in IDLE must not launch a sweep.
        @(posedge clk); #1;
        i_start = 1'b1; i_abort = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("start_abort_idle_busy", 64'(o_busy), 64'h0);

        run_sweep(1'b0, 32'h0100_0000, 32'h0080_0000, 3, 2, 1, 7, 1'b1, 1'b0);
        run_sweep(1'b0, 32'h0100_0000, 32'h0080_0000, 3, 2, 1, 0, 1'b0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            lp  = 1'($urandom);
            n   = $urandom_range(0, 5);
            dw  = $urandom_range(0, 3);
            dv  = $urandom_range(0, 3);
            rs  = ($urandom_range(0, 3) == 0);
            cut = lp ? $urandom_range(1, 50) : ($urandom_range(0, 1) ? $urandom_range(1, 60) : 0);
            run_sweep(lp, $urandom, $urandom, n, dw, dv, cut, rs, 1'($urandom));
        end

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Frequency-sweep sequencer that drives the phase-step load (`ld`/`dphase`) and sample-enable (`ce`) inputs of the table-lookup NCO. On a start request it captures a sweep description: start step, step increment, step count, dwell and sample-rate divider. It then walks the NCO through a linear staircase of phase steps, holding each for a fixed number of output samples. It sits between the host/config registers and the NCO and is the only agent that writes the NCO's step register.

## Interface
- `W`, 32, phase-step width; must equal NCO `W`
- `NW`, 16, width of step count / step index
- `DW`, 16, width of dwell count
- `CW`, 16, width of sample-rate divider

- `i_clk`  in  1  clock
- `i_reset`  in  1  reset, synchronous, active-high
- `i_start`  in  1  start request; honoured only in IDLE
- `i_abort`  in  1  stop sweep; priority over `i_start`
- `i_loop`  in  1  0 = single sweep, 1 = repeat forever; captured at start
- `i_f_start`  in  W  first phase step
- `i_f_step`  in  W  increment added per step, modulo 2^W
- `i_n_steps`  in  NW  number of steps in a sweep; 0 treated as 1
- `i_dwell`  in  DW  samples (`o_ce` pulses) per step; 0 treated as 1
- `i_div`  in  CW  `o_ce` asserted once per `i_div`+1 clocks
- `o_ld`  out  1  load strobe to NCO `i_ld`
- `o_dphase`  out  W  step value to NCO `i_dphase`
- `o_ce`  out  1  sample enable to NCO `i_ce`
- `o_busy`  out  1  high in LOAD and RUN
- `o_done`  out  1  one-cycle pulse at end of a single sweep
- `o_step_idx`  out  NW  index of the step currently loaded

## Operation
- States: IDLE, LOAD, RUN. Reset → IDLE.
- All config inputs are sampled into shadow registers on the accepted-start edge; later input changes have no effect until the next start.
- IDLE:
  - `o_ld` = `o_ce` = `o_busy` = 0.
  - `i_start` && !`i_abort`: capture config, cur ← `i_f_start`, idx ← 0, → LOAD.
- LOAD (exactly 1 cycle):
  - `o_ld` = 1, `o_dphase` = cur, `o_ce` = 0.
  - Clear div counter and dwell counter, → RUN.
- RUN:
  - Div counter counts 0..div; `o_ce` = 1 in the cycle it equals div, and the counter wraps to 0. div = 0 → `o_ce` every cycle.
  - Each `o_ce` increments the dwell counter. On the `o_ce` that completes the dwell:
    - idx < n−1: cur ← cur + step (truncated to W bits), idx++, → LOAD.
    - idx = n−1, loop = 1: cur ← f_start, idx ← 0, → LOAD.
    - idx = n−1, loop = 0: → IDLE; `o_done` = 1 in the first IDLE cycle.
- `i_abort` in any state: → IDLE next cycle. `o_ld`/`o_ce` are 0 from that cycle on, and no `o_done` pulse is generated.
- `i_start` while busy is ignored (no restart, no queueing).
- `o_dphase` and `o_step_idx` are registered and hold their last values in IDLE.
- Reset values: `o_ld` = `o_ce` = `o_busy` = `o_done` = 0, `o_dphase` = 0, `o_step_idx` = 0. Reset mid-sweep → IDLE next cycle and overrides everything.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Start sampled at edge of cycle 0 → `o_busy` = 1 and `o_ld` = 1 in cycle 1; RUN begins in cycle 2; first `o_ce` in cycle 2 + div.
- The NCO step register updates at the end of the LOAD cycle, so every `o_ce` in RUN uses the new step.
- Step period = 1 + dwell·(div+1) clocks. A single sweep occupies n·(1 + dwell·(div+1)) busy cycles; `o_done` follows in the next cycle.
- Loop mode: consecutive sweeps are back-to-back with no gap beyond the normal LOAD cycle.

## Test plan
- Basic sweep: f_start = 0x01000000, f_step = 0x00800000, n = 3, dwell = 2, div = 1, start at cycle 0 →
  - `o_ld` at cycles 1, 6, 11 with `o_dphase` 0x01000000, 0x01800000, 0x02000000;
  - `o_ce` at cycles 3, 5, 8, 10, 13, 15;
  - `o_busy` high in 1–15; `o_done` high in cycle 16 only.
- Wrap: f_start = 0xFFFFFFF0, f_step = 0x20, n = 2, dwell = 1, div = 0 → loads 0xFFFFFFF0 then 0x00000010; `o_ce` at cycles 2 and 4; `o_done` in cycle 5.
- Zero config: n = 0, dwell = 0, div = 0 → one LOAD (cycle 1), one `o_ce` (cycle 2), `o_done` in cycle 3.
- Loop and abort: loop = 1, n = 2, dwell = 1, div = 0 →
  - `o_ld` at cycles 1, 3, 5, 7… with idx 0, 1, 0, 1…;
  - `i_abort` in cycle 6 → cycle 7 IDLE, no `o_ld`/`o_ce`/`o_done`.
- Start while busy / abort vs start: pulse `i_start` mid-RUN with changed `i_f_start` → no effect on the sequence. Assert `i_start` and `i_abort` together in IDLE → stays IDLE.
- Reset mid-RUN: assert `i_reset` for 1 cycle during RUN → next cycle all outputs at reset values, state IDLE; a fresh start then behaves exactly as the basic sweep.
